// File: rtl/chip_test_sequencer.sv
// Scheduler for the chip-checker: launches one per-chip tester at a time (single chip or full scan),
// routes the active tester's pins to the shared socket and gathers pass/fail with a per-test watchdog.
module chip_test_sequencer #(
  parameter int NUM_CHIPS      = 4,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int SELW           = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Start,
  input  logic                    Scan,
  input  logic [SELW-1:0]         ChipSel,
  input  logic [NUM_CHIPS-1:0]    Tester_Done,
  input  logic [NUM_CHIPS-1:0]    Tester_RSLT,
  input  logic [14*NUM_CHIPS-1:0] Tester_Pins,
  output logic [NUM_CHIPS-1:0]    Tester_Run,
  output logic [NUM_CHIPS-1:0]    Tester_Disp,
  output logic [13:0]             Socket_Pins,
  output logic [SELW-1:0]         CurChip,
  output logic                    Busy,
  output logic                    ResultValid,
  output logic [NUM_CHIPS-1:0]    PassMask,
  output logic                    Timeout
);
  // state    | meaning
  // S_IDLE   | waiting for an accepted Start
  // S_LAUNCH | Run pulse to tester idx, watchdog cleared
  // S_WAIT   | waiting for Done from tester idx or watchdog expiry
  // S_ACK    | Disp pulse releases tester idx
  // S_NEXT   | advance to the next chip in a scan, or finish
  // S_REPORT | publish PassMask/Timeout via ResultValid

  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW1 = SELW + 1;
  localparam logic [TW-1:0]   T_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SELW-1:0] IDX_LAST = SELW'(NUM_CHIPS - 1);
  localparam logic [SELW:0]   NUM_C    = SW1'(NUM_CHIPS);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_ACK, S_NEXT, S_REPORT
  } state_t;

  state_t                state;
  logic [SELW-1:0]       idx;
  logic [TW-1:0]         timer;
  logic                  scan_q;
  logic [NUM_CHIPS-1:0]  sel_oh;
  logic                  done_sel;
  logic                  rslt_sel;

  assign Busy        = (state != S_IDLE);
  assign CurChip     = idx;
  assign Tester_Run  = (state == S_LAUNCH) ? sel_oh : '0;
  assign Tester_Disp = (state == S_ACK)    ? sel_oh : '0;

  // Explicit per-chip select keeps indexing in range for any NUM_CHIPS.
  always_comb begin
    sel_oh      = '0;
    done_sel    = 1'b0;
    rslt_sel    = 1'b0;
    Socket_Pins = '0;
    for (int i = 0; i < NUM_CHIPS; i++) begin
      if (idx == SELW'(i)) begin
        sel_oh[i] = 1'b1;
        done_sel  = Tester_Done[i];
        rslt_sel  = Tester_RSLT[i];
        if (Busy) Socket_Pins = Tester_Pins[14*i +: 14];
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= S_IDLE;
      idx         <= '0;
      timer       <= '0;
      scan_q      <= 1'b0;
      PassMask    <= '0;
      Timeout     <= 1'b0;
      ResultValid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start && (Scan || ({1'b0, ChipSel} < NUM_C))) begin
            scan_q      <= Scan;
            idx         <= Scan ? '0 : ChipSel;
            PassMask    <= '0;
            Timeout     <= 1'b0;
            ResultValid <= 1'b0;
            state       <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          timer <= timer + TW'(1);
          // Done takes priority over a watchdog expiry in the same cycle.
          if (done_sel) begin
            PassMask <= (PassMask & ~sel_oh) | (rslt_sel ? sel_oh : '0);
            state    <= S_ACK;
          end else if (timer == T_LAST) begin
            PassMask <= PassMask & ~sel_oh;
            Timeout  <= 1'b1;
            state    <= S_ACK;
          end
        end
        S_ACK: state <= S_NEXT;
        S_NEXT: begin
          if (scan_q && (idx != IDX_LAST)) begin
            idx   <= idx + SELW'(1);
            state <= S_LAUNCH;
          end else begin
            state <= S_REPORT;
          end
        end
        S_REPORT: begin
          ResultValid <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chip_test_sequencer.sv
// Directed bench for chip_test_sequencer: vector table of single/scan runs with hand-computed
// latencies and masks, plus sequences for busy-Start, mid-run reset and an 8-chip instance.
module tb_chip_test_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 4-chip instance with a short watchdog
  logic        start, scan;
  logic [1:0]  chip_sel;
  logic [3:0]  t_done, t_rslt;
  logic [55:0] t_pins;
  logic [3:0]  t_run, t_disp, pmask;
  logic [13:0] socket;
  logic [1:0]  cur;
  logic        busy, rv, tout;

  chip_test_sequencer #(.NUM_CHIPS(4), .TIMEOUT_CYCLES(16)) dut (
    .Clk(clk), .Reset(rst), .Start(start), .Scan(scan), .ChipSel(chip_sel),
    .Tester_Done(t_done), .Tester_RSLT(t_rslt), .Tester_Pins(t_pins),
    .Tester_Run(t_run), .Tester_Disp(t_disp), .Socket_Pins(socket), .CurChip(cur),
    .Busy(busy), .ResultValid(rv), .PassMask(pmask), .Timeout(tout)
  );

  // 8-chip instance, tester 5 answers immediately
  logic         start8, scan8;
  logic [2:0]   sel8, cur8;
  logic [7:0]   done8, rslt8, run8, disp8, pmask8;
  logic [111:0] pins8;
  logic [13:0]  socket8;
  logic         busy8, rv8, tout8;

  chip_test_sequencer #(.NUM_CHIPS(8)) dut8 (
    .Clk(clk), .Reset(rst), .Start(start8), .Scan(scan8), .ChipSel(sel8),
    .Tester_Done(done8), .Tester_RSLT(rslt8), .Tester_Pins(pins8),
    .Tester_Run(run8), .Tester_Disp(disp8), .Socket_Pins(socket8), .CurChip(cur8),
    .Busy(busy8), .ResultValid(rv8), .PassMask(pmask8), .Timeout(tout8)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  logic [13:0] pat [4];
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Tester model: Done rises lat cycles after the Run cycle (8'hFF = never), held until Disp.
  logic [3:0][7:0] lat_cfg;
  int cnt [4];
  bit act [4];
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      t_done = '0;
      for (int i = 0; i < 4; i++) begin act[i] = 1'b0; cnt[i] = 0; end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (t_run[i]) begin act[i] = 1'b1; cnt[i] = 0; end
        else if (t_disp[i]) begin act[i] = 1'b0; t_done[i] = 1'b0; end
        else if (act[i]) cnt[i]++;
        if (act[i] && lat_cfg[i] != 8'hFF && cnt[i] >= int'(lat_cfg[i])) t_done[i] = 1'b1;
      end
    end
  end

  // Pulse recorder and per-cycle socket/CurChip checks against the chip last launched.
  int run_q[$];
  int disp_q[$];
  int run_cyc, disp_cyc, model_idx;
  always @(negedge clk) begin
    if (rst) model_idx = 0;
    else begin
      for (int i = 0; i < 4; i++)
        if (t_run[i]) begin run_q.push_back(i); model_idx = i; run_cyc = cyc; end
      for (int i = 0; i < 4; i++)
        if (t_disp[i]) begin disp_q.push_back(i); disp_cyc = cyc; end
      if (busy) begin
        check("socket_busy", socket, pat[model_idx]);
        check("cur_chip", cur, model_idx);
      end else begin
        check("socket_idle", socket, 14'h0);
      end
    end
  end

  typedef struct packed {
    logic            scan;
    logic [1:0]      sel;
    logic [3:0][7:0] lat;
    logic [3:0]      rslt;
    logic [3:0]      exp_mask;
    logic            exp_tout;
    logic [7:0]      exp_cycles;  // Start-sampling edge to ResultValid rise
    logic [7:0]      exp_gap;     // Disp cycle minus Run cycle (single mode)
    logic [2:0]      exp_runs;
    logic            poke;        // pulse Start again while busy
  } vec_t;

  vec_t vecs [8];

  task automatic run_vec(input vec_t v, input int n);
    int s0, k;
    @(negedge clk);
    lat_cfg  = v.lat;
    t_rslt   = v.rslt;
    scan     = v.scan;
    chip_sel = v.sel;
    run_q.delete();
    disp_q.delete();
    start = 1'b1;
    s0    = cyc;
    @(negedge clk);
    start = 1'b0;
    check($sformatf("v%0d_busy_start", n), busy, 1'b1);
    check($sformatf("v%0d_rv_cleared", n), rv, 1'b0);
    k = 0;
    while (rv !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
      if (v.poke && k == 3) begin start = 1'b1; scan = 1'b1; chip_sel = 2'd1; end
      else start = 1'b0;
    end
    #1;
    check($sformatf("v%0d_cycles", n), cyc - s0, v.exp_cycles);
    check($sformatf("v%0d_busy_end", n), busy, 1'b0);
    check($sformatf("v%0d_mask", n), pmask, v.exp_mask);
    check($sformatf("v%0d_timeout", n), tout, v.exp_tout);
    check($sformatf("v%0d_nrun", n), run_q.size(), v.exp_runs);
    check($sformatf("v%0d_ndisp", n), disp_q.size(), v.exp_runs);
    for (int j = 0; j < run_q.size(); j++)
      check($sformatf("v%0d_run_order%0d", n, j), run_q[j], v.scan ? j : int'(v.sel));
    for (int j = 0; j < disp_q.size(); j++)
      check($sformatf("v%0d_disp_order%0d", n, j), disp_q[j], v.scan ? j : int'(v.sel));
    if (!v.scan) check($sformatf("v%0d_gap", n), disp_cyc - run_cyc, v.exp_gap);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int k, s0;
    rst = 1'b1; start = 1'b0; scan = 1'b0; chip_sel = 2'd0;
    t_rslt = '0; lat_cfg = '1;
    pat[0] = 14'h1234; pat[1] = 14'h0F0F; pat[2] = 14'h2AAA; pat[3] = 14'h3555;
    t_pins = {pat[3], pat[2], pat[1], pat[0]};
    start8 = 1'b0; scan8 = 1'b0; sel8 = 3'd0;
    done8 = 8'h20; rslt8 = 8'h20;
    pins8 = '1;
    pins8[14*5 +: 14] = 14'h2B3C;

    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_run", t_run, 4'h0);
    check("rst_disp", t_disp, 4'h0);
    check("rst_socket", socket, 14'h0);
    check("rst_cur", cur, 2'd0);
    check("rst_rv", rv, 1'b0);
    check("rst_mask", pmask, 4'h0);
    check("rst_tout", tout, 1'b0);
    check("rst_busy8", busy8, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    vecs[0] = '{scan:1'b0, sel:2'd2, lat:{8'hFF, 8'd8, 8'hFF, 8'hFF}, rslt:4'b0100, exp_mask:4'b0100,
                exp_tout:1'b0, exp_cycles:8'd13, exp_gap:8'd9, exp_runs:3'd1, poke:1'b0};
    vecs[1] = '{scan:1'b1, sel:2'd0, lat:{8'd9, 8'd7, 8'd5, 8'd3}, rslt:4'b1101, exp_mask:4'b1101,
                exp_tout:1'b0, exp_cycles:8'd38, exp_gap:8'd0, exp_runs:3'd4, poke:1'b0};
    vecs[2] = '{scan:1'b0, sel:2'd3, lat:{8'hFF, 8'hFF, 8'hFF, 8'hFF}, rslt:4'b1000, exp_mask:4'b0000,
                exp_tout:1'b1, exp_cycles:8'd21, exp_gap:8'd17, exp_runs:3'd1, poke:1'b0};
    vecs[3] = '{scan:1'b0, sel:2'd1, lat:{8'hFF, 8'hFF, 8'd16, 8'hFF}, rslt:4'b0010, exp_mask:4'b0010,
                exp_tout:1'b0, exp_cycles:8'd21, exp_gap:8'd17, exp_runs:3'd1, poke:1'b0};
    vecs[4] = '{scan:1'b0, sel:2'd3, lat:{8'd1, 8'hFF, 8'hFF, 8'hFF}, rslt:4'b0111, exp_mask:4'b0000,
                exp_tout:1'b0, exp_cycles:8'd6, exp_gap:8'd2, exp_runs:3'd1, poke:1'b0};
    vecs[5] = '{scan:1'b1, sel:2'd0, lat:{8'd2, 8'hFF, 8'd2, 8'd2}, rslt:4'b1111, exp_mask:4'b1011,
                exp_tout:1'b1, exp_cycles:8'd36, exp_gap:8'd0, exp_runs:3'd4, poke:1'b0};
    vecs[6] = '{scan:1'b0, sel:2'd0, lat:{8'hFF, 8'hFF, 8'hFF, 8'd15}, rslt:4'b0001, exp_mask:4'b0001,
                exp_tout:1'b0, exp_cycles:8'd20, exp_gap:8'd16, exp_runs:3'd1, poke:1'b0};
    vecs[7] = '{scan:1'b0, sel:2'd0, lat:{8'hFF, 8'hFF, 8'hFF, 8'd10}, rslt:4'b0001, exp_mask:4'b0001,
                exp_tout:1'b0, exp_cycles:8'd15, exp_gap:8'd11, exp_runs:3'd1, poke:1'b1};

    for (int n = 0; n < 8; n++) run_vec(vecs[n], n);

    repeat (3) @(negedge clk);
    check("hold_rv", rv, 1'b1);
    check("hold_mask", pmask, 4'b0001);
    check("hold_busy", busy, 1'b0);

    // Reset during chip 1's WAIT in a scan.
    @(negedge clk);
    lat_cfg = {8'd9, 8'd7, 8'd5, 8'd3};
    t_rslt = 4'b1111; scan = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (t_run[1] !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    check("rstseq_run1_seen", t_run[1], 1'b1);
    repeat (3) @(negedge clk);
    check("rstseq_pre_mask", pmask, 4'b0001);
    check("rstseq_pre_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rstseq_busy", busy, 1'b0);
    check("rstseq_run", t_run, 4'h0);
    check("rstseq_disp", t_disp, 4'h0);
    check("rstseq_socket", socket, 14'h0);
    check("rstseq_cur", cur, 2'd0);
    check("rstseq_rv", rv, 1'b0);
    check("rstseq_mask", pmask, 4'h0);
    check("rstseq_tout", tout, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(vecs[1], 100);

    // 8-chip instance, ChipSel=5
    @(negedge clk);
    sel8 = 3'd5; start8 = 1'b1; s0 = cyc;
    @(negedge clk);
    start8 = 1'b0;
    check("c8_run", run8, 8'h20);
    check("c8_cur", cur8, 3'd5);
    check("c8_busy", busy8, 1'b1);
    check("c8_socket", socket8, 14'h2B3C);
    repeat (2) @(negedge clk);
    check("c8_disp", disp8, 8'h20);
    k = 0;
    while (rv8 !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    check("c8_cycles", cyc - s0, 6);
    check("c8_mask", pmask8, 8'h20);
    check("c8_tout", tout8, 1'b0);
    check("c8_socket_idle", socket8, 14'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
